// File: rtl/wta_winner_monitor.sv
// -----------------------------------------------------------------------------
// wta_winner_monitor
//   Downstream monitor for a 2-channel winner-take-all stage. The incoming byte
//   carries the high-channel amplitude in [7:4] and the low-channel amplitude in
//   [3:0]; the losing nibble is normally zero. The winner class must be seen on
//   HOLD_CYCLES enabled samples before it locks. While locked, the monitor
//   reports the winner, its latest amplitude and a saturating streak count.
//   A sample with both nibbles nonzero is malformed and raises err.
//
// Ports
//   clk           in   rising-edge clock
//   rst           in   synchronous active-high reset (overrides en)
//   en            in   sample enable
//   u_in[7:0]     in   winner-take-all output vector
//   winner[1:0]   out  00 none, 01 high channel, 10 low channel
//   winner_valid  out  one-cycle pulse on every new lock
//   amp[3:0]      out  amplitude of the locked winner
//   streak        out  samples the current winner has held (saturating)
//   err           out  one-cycle pulse for a sample with both nibbles nonzero
//   switch_cnt    out  locks onto a class differing from the previous lock
//                      (present only with WTA_MON_SWITCH_CNT_EN defined)
//
// Optional feature macro: WTA_MON_SWITCH_CNT_EN
// -----------------------------------------------------------------------------
module wta_winner_monitor #(
   parameter int HOLD_CYCLES = 4,
   parameter int CNT_W       = 8,
   parameter int THRESH      = 1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             en,
   input  logic [7:0]       u_in,
   output logic [1:0]       winner,
   output logic             winner_valid,
   output logic [3:0]       amp,
   output logic [CNT_W-1:0] streak,
   output logic             err
`ifdef WTA_MON_SWITCH_CNT_EN
   ,
   output logic [CNT_W-1:0] switch_cnt
`endif
);

   typedef enum logic [1:0] {
      ST_IDLE   = 2'b00,
      ST_CAND   = 2'b01,
      ST_LOCKED = 2'b10
   } state_t;

   localparam logic [1:0]       CLS_NONE   = 2'b00;
   localparam logic [1:0]       CLS_HI     = 2'b01;
   localparam logic [1:0]       CLS_LO     = 2'b10;
   localparam logic [3:0]       THR        = 4'(THRESH);
   localparam logic [CNT_W-1:0] HOLD_C     = CNT_W'(HOLD_CYCLES);
   localparam logic [CNT_W-1:0] CNT_ONE    = {{(CNT_W-1){1'b0}}, 1'b1};
   localparam logic [CNT_W-1:0] STREAK_MAX = {CNT_W{1'b1}};

   state_t           r_state;
   logic [1:0]       r_cand;
   logic [CNT_W-1:0] r_cnt;
   logic [1:0]       r_winner;
   logic [3:0]       r_amp;
   logic [CNT_W-1:0] r_streak;
   logic             r_valid;
   logic             r_err;

   state_t           w_state_nx;
   logic [1:0]       w_cand_nx;
   logic [CNT_W-1:0] w_cnt_nx;
   logic [1:0]       w_winner_nx;
   logic [3:0]       w_amp_nx;
   logic [CNT_W-1:0] w_streak_nx;
   logic             w_valid_nx;
   logic             w_err_nx;
   logic             w_lock;

   logic [3:0]       w_hi;
   logic [3:0]       w_lo;
   logic [1:0]       w_cls;
   logic [3:0]       w_nib;
   logic             w_both;

   assign w_hi   = u_in[7:4];
   assign w_lo   = u_in[3:0];
   assign w_both = (w_hi != 4'd0) && (w_lo != 4'd0);

   // Classify the incoming sample and pick the amplitude of its active channel.
   always_comb begin
      w_cls = CLS_NONE;
      w_nib = 4'd0;
      if ((w_hi >= THR) && (w_lo == 4'd0)) begin
         w_cls = CLS_HI;
         w_nib = w_hi;
      end else if ((w_lo >= THR) && (w_hi == 4'd0)) begin
         w_cls = CLS_LO;
         w_nib = w_lo;
      end else begin
         w_cls = CLS_NONE;
         w_nib = 4'd0;
      end
   end

   // Next-state and next-output logic of the debounce FSM.
   always_comb begin
      w_state_nx  = r_state;
      w_cand_nx   = r_cand;
      w_cnt_nx    = r_cnt;
      w_winner_nx = r_winner;
      w_amp_nx    = r_amp;
      w_streak_nx = r_streak;
      w_valid_nx  = 1'b0;
      w_err_nx    = 1'b0;
      w_lock      = 1'b0;
      if (en) begin
         w_err_nx = w_both;
         if (w_cls == CLS_NONE) begin
            // Only dropping out of a lock clears the reported winner;
            // abandoning a candidate leaves the retained outputs alone.
            w_state_nx = ST_IDLE;
            if (r_state == ST_LOCKED) begin
               w_winner_nx = CLS_NONE;
               w_amp_nx    = 4'd0;
               w_streak_nx = {CNT_W{1'b0}};
            end else begin
               w_winner_nx = r_winner;
            end
         end else begin
            case (r_state)
               ST_LOCKED: begin
                  if (w_cls == r_winner) begin
                     w_amp_nx = w_nib;
                     if (r_streak != STREAK_MAX) begin
                        w_streak_nx = r_streak + CNT_ONE;
                     end else begin
                        w_streak_nx = r_streak;
                     end
                  end else begin
                     w_state_nx = ST_CAND;
                     w_cand_nx  = w_cls;
                     w_cnt_nx   = CNT_ONE;
                     w_lock     = (HOLD_C == CNT_ONE);
                  end
               end
               ST_CAND: begin
                  if (w_cls == r_cand) begin
                     w_cnt_nx = r_cnt + CNT_ONE;
                     w_lock   = ((r_cnt + CNT_ONE) == HOLD_C);
                  end else begin
                     w_cand_nx = w_cls;
                     w_cnt_nx  = CNT_ONE;
                     w_lock    = (HOLD_C == CNT_ONE);
                  end
               end
               default: begin
                  w_state_nx = ST_CAND;
                  w_cand_nx  = w_cls;
                  w_cnt_nx   = CNT_ONE;
                  w_lock     = (HOLD_C == CNT_ONE);
               end
            endcase
            // Lock action overrides whatever the candidate path chose.
            if (w_lock) begin
               w_state_nx  = ST_LOCKED;
               w_winner_nx = w_cls;
               w_amp_nx    = w_nib;
               w_streak_nx = HOLD_C;
               w_valid_nx  = 1'b1;
            end else begin
               w_valid_nx  = 1'b0;
            end
         end
      end else begin
         w_err_nx = 1'b0;
      end
   end

   // FSM state and output registers.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state  <= ST_IDLE;
         r_cand   <= CLS_NONE;
         r_cnt    <= {CNT_W{1'b0}};
         r_winner <= CLS_NONE;
         r_amp    <= 4'd0;
         r_streak <= {CNT_W{1'b0}};
         r_valid  <= 1'b0;
         r_err    <= 1'b0;
      end else begin
         r_state  <= w_state_nx;
         r_cand   <= w_cand_nx;
         r_cnt    <= w_cnt_nx;
         r_winner <= w_winner_nx;
         r_amp    <= w_amp_nx;
         r_streak <= w_streak_nx;
         r_valid  <= w_valid_nx;
         r_err    <= w_err_nx;
      end
   end

   assign winner       = r_winner;
   assign winner_valid = r_valid;
   assign amp          = r_amp;
   assign streak       = r_streak;
   assign err          = r_err;

`ifdef WTA_MON_SWITCH_CNT_EN
   // Last locked class persists across drops to IDLE; CLS_NONE means
   // nothing has locked since reset, so the first lock is not a switch.
   logic [1:0]       r_last_cls;
   logic [CNT_W-1:0] r_switch_cnt;
   logic [1:0]       w_last_cls_nx;
   logic [CNT_W-1:0] w_switch_cnt_nx;

   // Count locks whose class differs from the previous lock.
   always_comb begin
      w_last_cls_nx   = r_last_cls;
      w_switch_cnt_nx = r_switch_cnt;
      if (w_lock) begin
         w_last_cls_nx = w_cls;
         if ((r_last_cls != CLS_NONE) && (r_last_cls != w_cls)) begin
            w_switch_cnt_nx = r_switch_cnt + CNT_ONE;
         end else begin
            w_switch_cnt_nx = r_switch_cnt;
         end
      end else begin
         w_last_cls_nx = r_last_cls;
      end
   end

   // Switch counter registers.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_last_cls   <= CLS_NONE;
         r_switch_cnt <= {CNT_W{1'b0}};
      end else begin
         r_last_cls   <= w_last_cls_nx;
         r_switch_cnt <= w_switch_cnt_nx;
      end
   end

   assign switch_cnt = r_switch_cnt;
`endif

endmodule
